// File: rtl/spi_adc_rx.sv
// spi_adc_rx: SPI master receiver for serial ADC / microphone front-ends.
//
// Generates SCK (CPOL=1) and one active-low chip select per channel from clk,
// shifts MISO in MSB-first on every SCK rising edge, and hands each finished
// word plus its channel index to a valid/ready consumer. Frames run either
// single-shot or continuously, round-robin across NUM_CH devices.
//
// Optional feature, enabled by defining SPI_ADC_RX_OVERRUN_EN:
//   ovr_clr  in   1  clears overrun and drop_cnt
//   overrun  out  1  sticky, set when a finished frame is dropped
//   drop_cnt out  8  saturating count of dropped frames
//
// Ports:
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous active-low reset
//   enable     in   1       permits new frames
//   continuous in   1       1 = auto-restart after each frame
//   start      in   1       frame / run request, honoured only when idle
//   miso       in   1       serial data from the ADC
//   sck        out  1       SPI clock, idle high
//   cs_n       out  NUM_CH  one-hot-low chip selects
//   data       out  DATA_W  captured word
//   ch         out  CH_W    channel of data
//   valid      out  1       data/ch valid
//   ready      in   1       consumer accepts when valid && ready
//   busy       out  1       any state other than idle
module spi_adc_rx #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_CH  = 1,
  parameter int unsigned GAP_CYC = 2,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              continuous,
  input  logic              start,
  input  logic              miso,
  output logic              sck,
  output logic [NUM_CH-1:0] cs_n,
  output logic [DATA_W-1:0] data,
  output logic [CH_W-1:0]   ch,
  output logic              valid,
  input  logic              ready,
  output logic              busy
`ifdef SPI_ADC_RX_OVERRUN_EN
  ,
  input  logic              ovr_clr,
  output logic              overrun,
  output logic [7:0]        drop_cnt
`endif
);

  // One counter serves both the SCK half-period divider and the gap timer.
  localparam int unsigned CntMax = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BitW   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              sck_q, sck_d;
  logic [CH_W-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic [CH_W-1:0]   ch_q;
  logic              valid_q;
  logic              shift_en;
  logic              frame_done;
  logic              load;

  assign ptr_inc = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + CH_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    ptr_d    = ptr_q;
    shift_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        sck_d = 1'b1;
        cnt_d = '0;
        bit_d = '0;
        if (start && enable) state_d = StSetup;
      end
      StSetup: begin
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          // sck is low here, so this edge drives it high: sample miso.
          if (!sck_q) begin
            shift_en = 1'b1;
            bit_d    = bit_q + BitW'(1);
            if (bit_q == BitW'(DATA_W - 1)) begin
              bit_d   = '0;
              state_d = StGap;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          ptr_d   = ptr_inc;
          state_d = (continuous && enable) ? StSetup : StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The first gap cycle is where a finished word is offered to the output register.
  assign frame_done = (state_q == StGap) && (cnt_q == '0);
  assign load       = frame_done && (!valid_q || ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b1;
      ptr_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      ptr_q   <= ptr_d;
      if (shift_en) shift_q <= {shift_q[DATA_W-2:0], miso};
      if (load) begin
        data_q  <= shift_q;
        ch_q    <= ptr_q;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    cs_n = '1;
    if (state_q == StSetup || state_q == StShift) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ptr_q == CH_W'(i)) cs_n[i] = 1'b0;
      end
    end
  end

  assign sck   = sck_q;
  assign data  = data_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign busy  = (state_q != StIdle);

`ifdef SPI_ADC_RX_OVERRUN_EN
  logic       drop;
  logic       overrun_q;
  logic [7:0] drop_cnt_q;

  assign drop = frame_done && valid_q && !ready;

  // A drop in the same cycle as a clear still registers as the first drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overrun_q <= 1'b1;
      if (ovr_clr) begin
        drop_cnt_q <= 8'd1;
      end else if (drop_cnt_q != 8'hff) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end else if (ovr_clr) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spi_adc_rx.sv
// tb_spi_adc_rx: directed bench for spi_adc_rx with random data words.
// A behavioural ADC model serves queued words on miso; a negedge monitor
// records frames, sck edges and accepted words; expected values come from
// the frame timing arithmetic and a round-robin channel model.
// Overrun checks are compiled in when SPI_ADC_RX_OVERRUN_EN is defined.
module tb_spi_adc_rx;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned GAP_CYC = 2;
  localparam int unsigned CH_W    = 1;
  localparam int CS_LOW = CLK_DIV + 2 * DATA_W * CLK_DIV;
  localparam int PERIOD = CS_LOW + GAP_CYC;

  logic              clk, rst_n, enable, continuous, start, miso, ready;
  logic              sck, valid, busy;
  logic [NUM_CH-1:0] cs_n;
  logic [DATA_W-1:0] data;
  logic [CH_W-1:0]   ch;
`ifdef SPI_ADC_RX_OVERRUN_EN
  logic              ovr_clr, overrun;
  logic [7:0]        drop_cnt;
`endif

  spi_adc_rx #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV),
    .NUM_CH (NUM_CH),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .continuous(continuous),
    .start     (start),
    .miso      (miso),
    .sck       (sck),
    .cs_n      (cs_n),
    .data      (data),
    .ch        (ch),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy)
`ifdef SPI_ADC_RX_OVERRUN_EN
    ,
    .ovr_clr   (ovr_clr),
    .overrun   (overrun),
    .drop_cnt  (drop_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] tx_q[$];
  logic [DATA_W-1:0] acc_d[$];
  logic [CH_W-1:0]   acc_c[$];
  logic [NUM_CH-1:0] cs_q[$];
  int                len_q[$];
  int                start_q[$];
  int                gap_q[$];
  int                rises, vcyc, busy_cyc, stable_err, cyc;
  logic              have_end;
  int                m_ptr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ADC model: presents the next queued word MSB-first, changing after sck falls.
  initial begin
    logic [DATA_W-1:0] cur;
    int                nf;
    logic              act_p, sck_p;
    cur = '0; nf = 0; act_p = 1'b0; sck_p = 1'b1; miso = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cs_n != '1 && !act_p) begin
        cur = '0;
        if (tx_q.size() > 0) cur = tx_q.pop_front();
        nf   = 0;
        miso = cur[DATA_W-1];
      end else if (cs_n != '1 && sck_p && !sck && nf < int'(DATA_W)) begin
        miso = cur[DATA_W-1-nf];
        nf++;
      end
      act_p = (cs_n != '1);
      sck_p = sck;
    end
  end

  // Monitor on the falling clk edge, away from every DUT update.
  initial begin
    logic              psck, pval, prdy, prst, in_frame;
    logic [DATA_W-1:0] pdata;
    logic [CH_W-1:0]   pch;
    logic [NUM_CH-1:0] cur_cs;
    int                cur_len, end_cyc;
    psck = 1'b1; pval = 1'b0; prdy = 1'b0; prst = 1'b0; in_frame = 1'b0;
    pdata = '0; pch = '0; cur_cs = '1; cur_len = 0; end_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prst && rst_n && pval && !prdy && (!valid || data !== pdata || ch !== pch))
        stable_err++;
      if (!rst_n) begin
        in_frame = 1'b0;
        have_end = 1'b0;
      end else begin
        if (sck && !psck) rises++;
        if (valid) vcyc++;
        if (busy) busy_cyc++;
        if (valid && ready) begin
          acc_d.push_back(data);
          acc_c.push_back(ch);
        end
        if (cs_n != '1) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            cur_len  = 0;
            cur_cs   = cs_n;
            start_q.push_back(cyc);
            if (have_end) gap_q.push_back(cyc - end_cyc - 1);
          end
          cur_len++;
        end else if (in_frame) begin
          in_frame = 1'b0;
          len_q.push_back(cur_len);
          cs_q.push_back(cur_cs);
          have_end = 1'b1;
          end_cyc  = cyc - 1;
        end
      end
      psck = sck; pval = valid; prdy = ready; prst = rst_n; pdata = data; pch = ch;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clr_stats();
    acc_d.delete(); acc_c.delete(); cs_q.delete(); len_q.delete();
    start_q.delete(); gap_q.delete();
    rises = 0; vcyc = 0; busy_cyc = 0; stable_err = 0; have_end = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) break;
      step();
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Model: expected cs_n for a channel, and round-robin channel sequence.
  function automatic logic [NUM_CH-1:0] exp_cs(input int c);
    logic [NUM_CH-1:0] e;
    e    = '1;
    e[c] = 1'b0;
    return e;
  endfunction

  function automatic int next_ch();
    int c;
    c     = m_ptr;
    m_ptr = (m_ptr + 1) % NUM_CH;
    return c;
  endfunction

  initial begin
    logic [DATA_W-1:0] w [3];
    int                c [3];
    logic              psck;
    int                r;
    rises = 0; vcyc = 0; busy_cyc = 0; stable_err = 0; cyc = 0; have_end = 1'b0;
    rst_n = 1'b0; enable = 1'b0; continuous = 1'b0; start = 1'b0; ready = 1'b0;
`ifdef SPI_ADC_RX_OVERRUN_EN
    ovr_clr = 1'b0;
`endif
    m_ptr = 0;

    // Reset state
    step(3);
    chk("rst_sck", 32'(sck), 32'd1);
    chk("rst_cs_n", 32'(cs_n), 32'(exp_cs(0) | exp_cs(1)));
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ch", 32'(ch), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    ready = 1'b1;
    step(2);

    // Single shot
    clr_stats();
    tx_q.push_back(16'hA5C3);
    c[0] = next_ch();
    pulse_start();
    wait_idle("single_idle", 200);
    step(2);
    chk("single_frames", 32'(len_q.size()), 32'd1);
    chk("single_cs_len", 32'(len_q.size() > 0 ? len_q[0] : -1), 32'(CS_LOW));
    chk("single_cs", 32'(cs_q.size() > 0 ? cs_q[0] : '1), 32'(exp_cs(c[0])));
    chk("single_rises", 32'(rises), 32'd16);
    chk("single_acc", 32'(acc_d.size()), 32'd1);
    chk("single_data", 32'(acc_d.size() > 0 ? acc_d[0] : '0), 32'h0000A5C3);
    chk("single_ch", 32'(acc_c.size() > 0 ? acc_c[0] : 1'bx), 32'(c[0]));
    chk("single_valid_cyc", 32'(vcyc), 32'd1);
    chk("single_busy_cyc", 32'(busy_cyc), 32'(PERIOD));

    // Continuous round-robin from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    m_ptr = 0;
    clr_stats();
    for (int i = 0; i < 3; i++) begin
      w[i] = DATA_W'($urandom);
      c[i] = next_ch();
      tx_q.push_back(w[i]);
    end
    continuous = 1'b1;
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (len_q.size() >= 2 && cs_n != '1) break;
      step();
    end
    chk("cont_third_started", 32'(len_q.size()), 32'd2);
    continuous = 1'b0;
    wait_idle("cont_idle", 300);
    step(2);
    chk("cont_acc", 32'(acc_d.size()), 32'd3);
    for (int i = 0; i < 3 && i < acc_d.size(); i++) begin
      chk($sformatf("cont_data%0d", i), 32'(acc_d[i]), 32'(w[i]));
      chk($sformatf("cont_ch%0d", i), 32'(acc_c[i]), 32'(c[i]));
      chk($sformatf("cont_cs%0d", i), 32'(cs_q[i]), 32'(exp_cs(c[i])));
    end
    for (int i = 0; i < gap_q.size(); i++)
      chk($sformatf("cont_gap%0d", i), 32'(gap_q[i]), 32'(GAP_CYC));
    for (int i = 1; i < start_q.size(); i++)
      chk($sformatf("cont_period%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(PERIOD));

    // Backpressure: two frames with ready low, second one dropped
    clr_stats();
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w[i] = DATA_W'($urandom);
      c[i] = next_ch();
      tx_q.push_back(w[i]);
    end
    continuous = 1'b1;
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      if (len_q.size() >= 1 && cs_n != '1) break;
      step();
    end
    continuous = 1'b0;
    wait_idle("bp_idle", 300);
    step(2);
    chk("bp_frames", 32'(len_q.size()), 32'd2);
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_data_held", 32'(data), 32'(w[0]));
    chk("bp_ch_held", 32'(ch), 32'(c[0]));
    chk("bp_stable", 32'(stable_err), 32'd0);
    chk("bp_no_accept", 32'(acc_d.size()), 32'd0);
`ifdef SPI_ADC_RX_OVERRUN_EN
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    ready = 1'b1;
    step(2);
    chk("bp_accept", 32'(acc_d.size()), 32'd1);
    chk("bp_accept_data", 32'(acc_d.size() > 0 ? acc_d[0] : '0), 32'(w[0]));
    chk("bp_valid_clr", 32'(valid), 32'd0);
`ifdef SPI_ADC_RX_OVERRUN_EN
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("bp_ovr_clr", 32'(overrun), 32'd0);
    chk("bp_cnt_clr", 32'(drop_cnt), 32'd0);
`endif

    // Accept and load in the same cycle
    clr_stats();
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w[i] = DATA_W'($urandom);
      c[i] = next_ch();
      tx_q.push_back(w[i]);
    end
    pulse_start();
    wait_idle("sim_idle_a", 200);
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (cs_n == '1) break;
      step();
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    wait_idle("sim_idle_b", 200);
    step(2);
    chk("sim_acc_a", 32'(acc_d.size()), 32'd1);
    chk("sim_acc_a_data", 32'(acc_d.size() > 0 ? acc_d[0] : '0), 32'(w[0]));
    chk("sim_acc_a_ch", 32'(acc_c.size() > 0 ? acc_c[0] : 1'bx), 32'(c[0]));
    chk("sim_valid", 32'(valid), 32'd1);
    chk("sim_data_new", 32'(data), 32'(w[1]));
    chk("sim_ch_new", 32'(ch), 32'(c[1]));
`ifdef SPI_ADC_RX_OVERRUN_EN
    chk("sim_no_drop", 32'(drop_cnt), 32'd0);
`endif
    ready = 1'b1;
    step(2);
    chk("sim_acc_b", 32'(acc_d.size()), 32'd2);
    chk("sim_valid_clr", 32'(valid), 32'd0);

    // Reset mid-frame at the 8th sck rising edge
    clr_stats();
    w[0] = DATA_W'($urandom);
    w[1] = DATA_W'($urandom);
    tx_q.push_back(w[0]);
    tx_q.push_back(w[1]);
    pulse_start();
    psck = sck;
    r    = 0;
    for (int i = 0; i < 200; i++) begin
      if (sck && !psck) r++;
      psck = sck;
      if (r == 8) break;
      step();
    end
    chk("mid_rise8", 32'(r), 32'd8);
    rst_n = 1'b0;
    #1;
    chk("mid_sck", 32'(sck), 32'd1);
    chk("mid_cs_n", 32'(cs_n), 32'(exp_cs(0) | exp_cs(1)));
    chk("mid_valid", 32'(valid), 32'd0);
    chk("mid_data", 32'(data), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    m_ptr = 0;
    clr_stats();
    c[1] = next_ch();
    pulse_start();
    wait_idle("mid_idle", 200);
    step(2);
    chk("mid_acc", 32'(acc_d.size()), 32'd1);
    chk("mid_clean_data", 32'(acc_d.size() > 0 ? acc_d[0] : '0), 32'(w[1]));
    chk("mid_clean_ch", 32'(acc_c.size() > 0 ? acc_c[0] : 1'bx), 32'(c[1]));
    chk("mid_rises", 32'(rises), 32'd16);

    // Control gating: start with enable low
    clr_stats();
    enable = 1'b0;
    pulse_start();
    step(5);
    chk("gate_en_busy", 32'(busy), 32'd0);
    chk("gate_en_cs", 32'(cs_n), 32'(exp_cs(0) | exp_cs(1)));

    // Start while busy
    enable = 1'b1;
    w[0] = DATA_W'($urandom);
    c[0] = next_ch();
    tx_q.push_back(w[0]);
    pulse_start();
    step(10);
    pulse_start();
    wait_idle("gate_busy_idle", 200);
    step(80);
    chk("gate_busy_frames", 32'(len_q.size()), 32'd1);
    chk("gate_busy_data", 32'(acc_d.size() > 0 ? acc_d[0] : '0), 32'(w[0]));
    chk("gate_busy_ch", 32'(acc_c.size() > 0 ? acc_c[0] : 1'bx), 32'(c[0]));

    // Enable dropped mid-frame in continuous mode
    clr_stats();
    tx_q.delete();
    w[0] = DATA_W'($urandom);
    w[1] = DATA_W'($urandom);
    c[0] = next_ch();
    tx_q.push_back(w[0]);
    tx_q.push_back(w[1]);
    continuous = 1'b1;
    pulse_start();
    step(20);
    enable = 1'b0;
    wait_idle("gate_drop_idle", 200);
    step(100);
    chk("gate_drop_frames", 32'(len_q.size()), 32'd1);
    chk("gate_drop_acc", 32'(acc_d.size()), 32'd1);
    chk("gate_drop_data", 32'(acc_d.size() > 0 ? acc_d[0] : '0), 32'(w[0]));
    chk("gate_drop_ch", 32'(acc_c.size() > 0 ? acc_c[0] : 1'bx), 32'(c[0]));
    chk("gate_drop_cs", 32'(cs_n), 32'(exp_cs(0) | exp_cs(1)));
    continuous = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
